// File: rtl/msrv32_wb_unit.sv
// ---------------------------------------------------------------------------
// msrv32_wb_unit
//
// Write-back stage of the msrv32 core and the only writer of the integer
// register file. One retiring instruction per cycle arrives from execute. The
// unit picks the result source and registers the register-file write
// controls. For loads it waits for the data-memory response, aligns and
// extends the returned data, and stalls upstream for the whole wait. A timeout
// counter limits how long that wait can last.
//
// Ports:
//   ms_riscv32_mp_clk_in  clock, rising edge
//   ms_riscv32_mp_rst_in  asynchronous active-low reset
//   wb_valid_in           execute presents a retiring instruction
//   wb_mux_sel_in         result source: 0 ALU, 1 LOAD, 2 IMM, 3 PC+4, 4 CSR
//   rd_addr_in            destination register
//   alu_result_in         ALU result
//   imm_in                immediate (LUI)
//   pc_plus_4_in          link value (JAL/JALR)
//   csr_data_in           CSR read value
//   load_size_in          0 byte, 1 half, 2/3 word
//   load_unsigned_in      1 = zero-extend, 0 = sign-extend
//   addr_lsb_in           byte offset of the load address
//   flush_in              abort any pending load / block acceptance
//   dm_data_in            data memory read word
//   dm_valid_in           data memory response valid
//   wb_stall_out          upstream must hold (combinational, WAIT_LOAD)
//   wr_en_out             register file write enable (registered)
//   rd_addr_out           register file write address (registered)
//   rd_out                register file write data (registered)
//   load_err_out          one-cycle pulse when a load times out (registered)
// ---------------------------------------------------------------------------
module msrv32_wb_unit #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        wb_valid_in,
    input  logic [2:0]  wb_mux_sel_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] csr_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [1:0]  addr_lsb_in,
    input  logic        flush_in,
    input  logic [31:0] dm_data_in,
    input  logic        dm_valid_in,
    output logic        wb_stall_out,
    output logic        wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        load_err_out
);

    localparam logic [2:0] SEL_ALU  = 3'd0;
    localparam logic [2:0] SEL_LOAD = 3'd1;
    localparam logic [2:0] SEL_IMM  = 3'd2;
    localparam logic [2:0] SEL_PC4  = 3'd3;
    localparam logic [2:0] SEL_CSR  = 3'd4;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [4:0]       hold_rd, hold_rd_next;
    logic [1:0]       hold_size, hold_size_next;
    logic             hold_unsigned, hold_unsigned_next;
    logic [1:0]       hold_lsb, hold_lsb_next;
    logic             wr_en_next;
    logic [4:0]       rd_addr_next;
    logic [31:0]      rd_next;
    logic             err_next;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_data;

    assign wb_stall_out = (state == WAIT_LOAD);

    // Align and extend the memory word using the attributes captured at
    // accept time. Halfword selection only looks at lsb[1]. A size of 3 is
    // treated as a word.
    always_comb begin
        load_byte = 8'h00;
        case (hold_lsb)
            2'd0:    load_byte = dm_data_in[7:0];
            2'd1:    load_byte = dm_data_in[15:8];
            2'd2:    load_byte = dm_data_in[23:16];
            default: load_byte = dm_data_in[31:24];
        endcase
        load_half = hold_lsb[1] ? dm_data_in[31:16] : dm_data_in[15:0];
        case (hold_size)
            2'd0:    load_data = {{24{~hold_unsigned & load_byte[7]}}, load_byte};
            2'd1:    load_data = {{16{~hold_unsigned & load_half[15]}}, load_half};
            default: load_data = dm_data_in;
        endcase
    end

    // Next-state and next-output logic. By default the write and error
    // pulses drop and the data/address registers keep their value. Writes
    // to x0 are suppressed here so that one check covers every source.
    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        hold_rd_next       = hold_rd;
        hold_size_next     = hold_size;
        hold_unsigned_next = hold_unsigned;
        hold_lsb_next      = hold_lsb;
        wr_en_next         = 1'b0;
        rd_addr_next       = rd_addr_out;
        rd_next            = rd_out;
        err_next           = 1'b0;

        case (state)
            IDLE: begin
                if (wb_valid_in && !flush_in) begin
                    case (wb_mux_sel_in)
                        SEL_LOAD: begin
                            hold_rd_next       = rd_addr_in;
                            hold_size_next     = load_size_in;
                            hold_unsigned_next = load_unsigned_in;
                            hold_lsb_next      = addr_lsb_in;
                            cnt_next           = '0;
                            state_next         = WAIT_LOAD;
                        end
                        SEL_ALU, SEL_IMM, SEL_PC4, SEL_CSR: begin
                            rd_addr_next = rd_addr_in;
                            wr_en_next   = (rd_addr_in != 5'd0);
                            case (wb_mux_sel_in)
                                SEL_ALU: rd_next = alu_result_in;
                                SEL_IMM: rd_next = imm_in;
                                SEL_PC4: rd_next = pc_plus_4_in;
                                default: rd_next = csr_data_in;
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end
            end
            WAIT_LOAD: begin
                if (flush_in) begin
                    state_next = IDLE;
                end else if (dm_valid_in) begin
                    rd_next      = load_data;
                    rd_addr_next = hold_rd;
                    wr_en_next   = (hold_rd != 5'd0);
                    state_next   = IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, holding and output registers. All of them clear on reset, so a
    // load that is pending when reset arrives is dropped without a write and
    // without an error pulse.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_rd       <= 5'd0;
            hold_size     <= 2'd0;
            hold_unsigned <= 1'b0;
            hold_lsb      <= 2'd0;
            wr_en_out     <= 1'b0;
            rd_addr_out   <= 5'd0;
            rd_out        <= 32'd0;
            load_err_out  <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            hold_rd       <= hold_rd_next;
            hold_size     <= hold_size_next;
            hold_unsigned <= hold_unsigned_next;
            hold_lsb      <= hold_lsb_next;
            wr_en_out     <= wr_en_next;
            rd_addr_out   <= rd_addr_next;
            rd_out        <= rd_next;
            load_err_out  <= err_next;
        end
    end

endmodule
